fetch_redirect_ctrl: RTL and testbench
======================================

# fetch_redirect_ctrl

Next-PC controller for the front end. It owns the fetch PC register and chooses among five sources: commit-level flush, execute-stage mispredict recovery, decode-stage (FS2) recovery, FS1 BTB prediction, and sequential increment. It holds redirects that arrive during a stall, and inserts refill bubbles after pipeline-wide flushes. It feeds `pc_i` of FetchStage1 and consumes `flagRecoverID_o`/`targetAddrID_o` from FetchStage2.

## Interface
- `SIZE_PC`, 32, PC width in bits.
- `RESET_PC`, 0, fetch address after reset.
- `FETCH_BLOCK_BYTES`, 32, sequential increment (4 instructions × 8 bytes).
- `REFILL_CYCLES`, 2, fetch-disabled cycles after a flush or EX recovery; legal range 1–15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stall_i` in 1: back-end stall or CTI-queue full; freezes the PC.
- `flush_i` in 1: commit-level flush request.
- `flushPC_i` in SIZE_PC: flush target.
- `recoverEX_i` in 1: execute-stage branch mispredict.
- `recoverEXPC_i` in SIZE_PC: corrected target from EX.
- `recoverID_i` in 1: FS2 predecode recovery.
- `recoverIDPC_i` in SIZE_PC: FS2 target.
- `btbTaken_i` in 1: FS1 predicts a taken CTI in the current block.
- `btbTarget_i` in SIZE_PC: predicted target.
- `pc_o` out SIZE_PC: current fetch PC.
- `fetchEn_o` out 1: FS1 may issue a fetch at `pc_o`.
- `squashFS1_o` out 1: kill the block currently in FS1 (combinational).
- `redirectSrc_o` out 3: source applied at the last PC update.

## Operation
- Source priority: flush > recoverEX > recoverID > BTB > sequential. Source encodings: SEQ=0, BTB=1, ID=2, EX=3, FLUSH=4.
- States:
  - RESET: entered whenever `reset` is high.
  - RUN
  - HOLD: stalled.
  - REFILL: bubble countdown.
- RESET → RUN on the first cycle after `reset` is low. `pc_o`=RESET_PC and `fetchEn_o`=0 while in RESET.
- In RUN with `stall_i`=0:
  - `pc_o` loads the winning source. With no redirect and no BTB hit, `pc_o` loads `pc_o`+FETCH_BLOCK_BYTES, mod 2^SIZE_PC, so wrap is silent.
  - A flush or EX winner enters REFILL with the counter at REFILL_CYCLES. An ID or BTB winner stays in RUN.
- In RUN with `stall_i`=1: `pc_o` holds and the state goes to HOLD.
  - A flush or EX arriving in that same cycle is latched into the pending register (valid, source, target).
  - `recoverID_i` and `btbTaken_i` are ignored whenever `stall_i`=1.
- HOLD:
  - A new flush or EX request overwrites the pending entry only if its priority is ≥ the stored one.
  - On `stall_i` falling: if pending is valid, apply it (load `pc_o`, clear pending, go to REFILL). Otherwise return to RUN with `pc_o` unchanged.
- REFILL:
  - `fetchEn_o`=0. The counter decrements each cycle and the state goes to RUN after the cycle in which it reaches 1.
  - A flush or EX arriving in REFILL loads its PC and restarts the counter.
  - `stall_i` is don't-care in REFILL.
- `squashFS1_o` = (flush | recoverEX | recoverID) & state==RUN & ~`stall_i`, or the cycle a pending entry is applied out of HOLD.
- `fetchEn_o`=1 only in RUN with `stall_i`=0.

## Timing
- Redirect to `pc_o` latency: 1 cycle. `redirectSrc_o` updates in the same edge.
- Reset values: `pc_o`=RESET_PC, `fetchEn_o`=0, `squashFS1_o`=0, `redirectSrc_o`=0, pending valid=0, counter=0, state=RESET.
- Reset asserted mid-HOLD or mid-REFILL discards the pending entry and the counter on the next edge.
- Flush and EX in the same cycle: flush target wins, and `redirectSrc_o`=4.
- Total fetch-disabled cycles after an unstalled flush: exactly REFILL_CYCLES.

## Configuration
- `FETCH_REDIRECT_STATS_EN` defined: three 16-bit saturating counters count applied redirects for FLUSH, EX and ID. They are output as `statFlush_o`, `statEX_o` and `statID_o`, clear on `reset`, and stick at 16'hFFFF.
- Undefined: the counters and their ports are absent, and the behaviour is otherwise identical.

## Structure
- Shared `fetch_pkg`:
  - redirect-source typedef (3-bit enum above)
  - state typedef (RESET/RUN/HOLD/REFILL)
  - `FETCH_BLOCK_BYTES` constant
- One sub-module, `fetch_redirect_prio`: a combinational priority select returning (valid, source, target). It is reused for both live inputs and the pending-entry merge.

## Test plan
- Release `reset` with RESET_PC=0x1000 → RESET for one cycle, then `pc_o`=0x1000, 0x1020, 0x1040 with `fetchEn_o`=1.
- `btbTaken_i`=1, `btbTarget_i`=0x2000 at `pc_o`=0x1020 → next `pc_o`=0x2000, `redirectSrc_o`=1, `squashFS1_o`=0, no bubble.
- `flush_i` (PC 0x4000) and `recoverEX_i` (PC 0x3000) in the same cycle → `pc_o`=0x4000, `redirectSrc_o`=4, `fetchEn_o`=0 for 2 cycles, then sequential 0x4020.
- `stall_i` held for 5 cycles; EX (0x3000) in cycle 1, flush (0x5000) in cycle 3 → `pc_o` frozen; on release `pc_o`=0x5000, `squashFS1_o` pulses once.
- `pc_o`=0xFFFFFFE0, sequential step → `pc_o`=0x00000000, no error.
- With the macro defined, apply 3 ID recoveries → `statID_o`=3; force 70000 recoveries → `statID_o` stays at 0xFFFF.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the front-end next-PC controller.
//   redirect_src_e : source applied at a PC update. The numeric order matches
//                    the priority order, so a larger code is a stronger request.
//   state_e        : controller states (RESET/RUN/HOLD/REFILL).
//   FETCH_BLOCK_BYTES : sequential fetch step (4 instructions x 8 bytes).
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ   = 3'd0,
    SRC_BTB   = 3'd1,
    SRC_ID    = 3'd2,
    SRC_EX    = 3'd3,
    SRC_FLUSH = 3'd4
  } redirect_src_e;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_RUN,
    ST_HOLD,
    ST_REFILL
  } state_e;

  localparam int FETCH_BLOCK_BYTES = 32;

endpackage

// File: rtl/fetch_redirect_if.sv
// ---------------------------------------------------------------------------
// fetch_redirect_if
// Bundles the redirect requests and fetch-control outputs of
// fetch_redirect_ctrl.
//   master : back end / FS1 / FS2 side; drives stall, flush, recoveries and
//            the BTB prediction, observes the fetch PC and control outputs.
//   slave  : the controller itself.
// With FETCH_REDIRECT_STATS_EN defined the three redirect statistics
// counters are part of the bundle as well.
// ---------------------------------------------------------------------------
interface fetch_redirect_if
  import fetch_pkg::*;
#(
  parameter int SIZE_PC = 32
);

  logic               stall_i;
  logic               flush_i;
  logic [SIZE_PC-1:0] flushPC_i;
  logic               recoverEX_i;
  logic [SIZE_PC-1:0] recoverEXPC_i;
  logic               recoverID_i;
  logic [SIZE_PC-1:0] recoverIDPC_i;
  logic               btbTaken_i;
  logic [SIZE_PC-1:0] btbTarget_i;

  logic [SIZE_PC-1:0] pc_o;
  logic               fetchEn_o;
  logic               squashFS1_o;
  redirect_src_e      redirectSrc_o;
`ifdef FETCH_REDIRECT_STATS_EN
  logic [15:0]        statFlush_o;
  logic [15:0]        statEX_o;
  logic [15:0]        statID_o;
`endif

  modport master (
    output stall_i, flush_i, flushPC_i, recoverEX_i, recoverEXPC_i,
           recoverID_i, recoverIDPC_i, btbTaken_i, btbTarget_i,
    input  pc_o, fetchEn_o, squashFS1_o, redirectSrc_o
`ifdef FETCH_REDIRECT_STATS_EN
    , input statFlush_o, statEX_o, statID_o
`endif
  );

  modport slave (
    input  stall_i, flush_i, flushPC_i, recoverEX_i, recoverEXPC_i,
           recoverID_i, recoverIDPC_i, btbTaken_i, btbTarget_i,
    output pc_o, fetchEn_o, squashFS1_o, redirectSrc_o
`ifdef FETCH_REDIRECT_STATS_EN
    , output statFlush_o, statEX_o, statID_o
`endif
  );

endinterface

// File: rtl/fetch_redirect_prio.sv
// ---------------------------------------------------------------------------
// fetch_redirect_prio
// Combinational priority select: flush > EX > ID > BTB among the live
// requests, then arbitration against a held entry. A live winner replaces the
// held entry when its priority is greater than or equal to the held one.
// Tie held_valid low to get a plain live-request select.
//   flush/ex/id/btb (+ *_pc) : live requests and targets
//   held_valid/src/pc        : previously captured entry
//   valid/src/pc             : winning entry
// ---------------------------------------------------------------------------
module fetch_redirect_prio
  import fetch_pkg::*;
#(
  parameter int SIZE_PC = 32
) (
  input  logic               flush,
  input  logic [SIZE_PC-1:0] flush_pc,
  input  logic               ex,
  input  logic [SIZE_PC-1:0] ex_pc,
  input  logic               id,
  input  logic [SIZE_PC-1:0] id_pc,
  input  logic               btb,
  input  logic [SIZE_PC-1:0] btb_pc,
  input  logic               held_valid,
  input  redirect_src_e      held_src,
  input  logic [SIZE_PC-1:0] held_pc,
  output logic               valid,
  output redirect_src_e      src,
  output logic [SIZE_PC-1:0] pc
);

  logic               live_valid;
  redirect_src_e      live_src;
  logic [SIZE_PC-1:0] live_pc;

  // NOTE: every variable gets a default at the top of the always_comb so no
  // path leaves it unassigned; that is what keeps a latch from being inferred.
  always_comb begin
    live_valid = 1'b1;
    live_src   = SRC_SEQ;
    live_pc    = '0;
    if (flush) begin
      live_src = SRC_FLUSH;
      live_pc  = flush_pc;
    end else if (ex) begin
      live_src = SRC_EX;
      live_pc  = ex_pc;
    end else if (id) begin
      live_src = SRC_ID;
      live_pc  = id_pc;
    end else if (btb) begin
      live_src = SRC_BTB;
      live_pc  = btb_pc;
    end else begin
      live_valid = 1'b0;
    end
  end

  // Encodings are ordered by priority, so a numeric compare gives ">=".
  always_comb begin
    valid = held_valid;
    src   = held_src;
    pc    = held_pc;
    if (live_valid && (!held_valid || live_src >= held_src)) begin
      valid = 1'b1;
      src   = live_src;
      pc    = live_pc;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl
// Next-PC controller for the front end. Owns the fetch PC and selects among
// commit flush, EX mispredict recovery, FS2 (ID) recovery, FS1 BTB prediction
// and sequential increment. Redirects that arrive while stalled are held in a
// pending entry; flushes and EX recoveries are followed by REFILL_CYCLES
// fetch-disabled bubbles.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : fetch_redirect_if.slave (requests in; pc_o, fetchEn_o,
//           squashFS1_o, redirectSrc_o out)
// Optional feature: define FETCH_REDIRECT_STATS_EN to add three 16-bit
// saturating counters of applied FLUSH / EX / ID redirects
// (statFlush_o, statEX_o, statID_o).
// ---------------------------------------------------------------------------
module fetch_redirect_ctrl #(
  parameter int                 SIZE_PC           = 32,
  parameter logic [SIZE_PC-1:0] RESET_PC          = '0,
  parameter int                 FETCH_BLOCK_BYTES = fetch_pkg::FETCH_BLOCK_BYTES,
  parameter int                 REFILL_CYCLES     = 2
) (
  input logic                clk,
  input logic                reset,
  fetch_redirect_if.slave    bus
);

  import fetch_pkg::*;

  state_e             state;
  logic [SIZE_PC-1:0] pc_q;
  redirect_src_e      src_q;
  logic [3:0]         refill_cnt;
  logic               pend_valid;
  redirect_src_e      pend_src;
  logic [SIZE_PC-1:0] pend_pc;

  logic               live_valid;
  redirect_src_e      live_src;
  logic [SIZE_PC-1:0] live_pc;
  logic               merge_valid;
  redirect_src_e      merge_src;
  logic [SIZE_PC-1:0] merge_pc;

  logic               apply_valid;
  redirect_src_e      apply_src;
  logic [SIZE_PC-1:0] apply_pc;

  // Live select over all four request sources.
  fetch_redirect_prio #(.SIZE_PC(SIZE_PC)) u_live (
    .flush(bus.flush_i),       .flush_pc(bus.flushPC_i),
    .ex(bus.recoverEX_i),      .ex_pc(bus.recoverEXPC_i),
    .id(bus.recoverID_i),      .id_pc(bus.recoverIDPC_i),
    .btb(bus.btbTaken_i),      .btb_pc(bus.btbTarget_i),
    .held_valid(1'b0),         .held_src(SRC_SEQ),
    .held_pc({SIZE_PC{1'b0}}),
    .valid(live_valid),        .src(live_src),          .pc(live_pc)
  );

  // Pending merge: only flush and EX can be captured while stalled.
  fetch_redirect_prio #(.SIZE_PC(SIZE_PC)) u_merge (
    .flush(bus.flush_i),       .flush_pc(bus.flushPC_i),
    .ex(bus.recoverEX_i),      .ex_pc(bus.recoverEXPC_i),
    .id(1'b0),                 .id_pc({SIZE_PC{1'b0}}),
    .btb(1'b0),                .btb_pc({SIZE_PC{1'b0}}),
    .held_valid(pend_valid),   .held_src(pend_src),     .held_pc(pend_pc),
    .valid(merge_valid),       .src(merge_src),         .pc(merge_pc)
  );

  // Redirect that will be loaded into the PC at the coming edge.
  always_comb begin
    apply_valid = 1'b0;
    apply_src   = SRC_SEQ;
    apply_pc    = pc_q;
    case (state)
      ST_RUN: if (!bus.stall_i && live_valid) begin
        apply_valid = 1'b1;
        apply_src   = live_src;
        apply_pc    = live_pc;
      end
      ST_HOLD: if (!bus.stall_i && merge_valid) begin
        apply_valid = 1'b1;
        apply_src   = merge_src;
        apply_pc    = merge_pc;
      end
      ST_REFILL: if (bus.flush_i || bus.recoverEX_i) begin
        apply_valid = 1'b1;
        apply_src   = live_src;
        apply_pc    = live_pc;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and simulation matches the hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RESET;
      pc_q       <= RESET_PC;
      src_q      <= SRC_SEQ;
      refill_cnt <= '0;
      pend_valid <= 1'b0;
      pend_src   <= SRC_SEQ;
      pend_pc    <= '0;
    end else begin
      case (state)
        ST_RESET: state <= ST_RUN;
        ST_RUN: begin
          if (bus.stall_i) begin
            state      <= ST_HOLD;
            pend_valid <= merge_valid;
            pend_src   <= merge_src;
            pend_pc    <= merge_pc;
          end else if (apply_valid) begin
            pc_q  <= apply_pc;
            src_q <= apply_src;
            if (apply_src == SRC_FLUSH || apply_src == SRC_EX) begin
              state      <= ST_REFILL;
              refill_cnt <= 4'(REFILL_CYCLES);
            end
          end else begin
            pc_q  <= pc_q + SIZE_PC'(FETCH_BLOCK_BYTES);
            src_q <= SRC_SEQ;
          end
        end
        ST_HOLD: begin
          if (bus.stall_i) begin
            pend_valid <= merge_valid;
            pend_src   <= merge_src;
            pend_pc    <= merge_pc;
          end else if (apply_valid) begin
            pc_q       <= apply_pc;
            src_q      <= apply_src;
            pend_valid <= 1'b0;
            state      <= ST_REFILL;
            refill_cnt <= 4'(REFILL_CYCLES);
          end else begin
            state <= ST_RUN;
          end
        end
        ST_REFILL: begin
          if (apply_valid) begin
            pc_q       <= apply_pc;
            src_q      <= apply_src;
            refill_cnt <= 4'(REFILL_CYCLES);
          end else if (refill_cnt == 4'd1) begin
            state      <= ST_RUN;
            refill_cnt <= '0;
          end else begin
            refill_cnt <= refill_cnt - 4'd1;
          end
        end
        default: state <= ST_RESET;
      endcase
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.redirectSrc_o = src_q;
  assign bus.fetchEn_o     = (state == ST_RUN) && !bus.stall_i;
  // ID/BTB never come out of HOLD, so a HOLD apply is always a flush or EX.
  assign bus.squashFS1_o   =
      ((bus.flush_i || bus.recoverEX_i || bus.recoverID_i) &&
       (state == ST_RUN) && !bus.stall_i) ||
      ((state == ST_HOLD) && !bus.stall_i && merge_valid);

`ifdef FETCH_REDIRECT_STATS_EN
  logic [15:0] stat_flush;
  logic [15:0] stat_ex;
  logic [15:0] stat_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_flush <= '0;
      stat_ex    <= '0;
      stat_id    <= '0;
    end else if (apply_valid) begin
      if (apply_src == SRC_FLUSH && stat_flush != 16'hFFFF) stat_flush <= stat_flush + 16'd1;
      if (apply_src == SRC_EX    && stat_ex    != 16'hFFFF) stat_ex    <= stat_ex + 16'd1;
      if (apply_src == SRC_ID    && stat_id    != 16'hFFFF) stat_id    <= stat_id + 16'd1;
    end
  end

  assign bus.statFlush_o = stat_flush;
  assign bus.statEX_o    = stat_ex;
  assign bus.statID_o    = stat_id;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_redirect_ctrl
// Directed self-checking bench for fetch_redirect_ctrl (RESET_PC=0x1000,
// REFILL_CYCLES=2). Each step drives one cycle of requests, checks the
// combinational squash, pushes the expected post-edge PC/enable/source into a
// scoreboard and pops it after the edge. Statistics checks are compiled in
// when FETCH_REDIRECT_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_fetch_redirect_ctrl;

  logic clk;
  logic reset;

  fetch_redirect_if #(.SIZE_PC(32)) bus ();

  fetch_redirect_ctrl #(
    .SIZE_PC(32),
    .RESET_PC(32'h0000_1000),
    .FETCH_BLOCK_BYTES(32),
    .REFILL_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        en;
    logic [2:0]  src;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_idle();
    bus.stall_i       = 1'b0;
    bus.flush_i       = 1'b0;
    bus.flushPC_i     = '0;
    bus.recoverEX_i   = 1'b0;
    bus.recoverEXPC_i = '0;
    bus.recoverID_i   = 1'b0;
    bus.recoverIDPC_i = '0;
    bus.btbTaken_i    = 1'b0;
    bus.btbTarget_i   = '0;
  endtask

  // One clock of stimulus; fetchEn is observed with stall released.
  task automatic cyc(input string tag,
                     input logic st, input logic fl, input logic [31:0] flpc,
                     input logic ex, input logic [31:0] expc,
                     input logic id, input logic [31:0] idpc,
                     input logic btb, input logic [31:0] btbpc,
                     input logic exp_sq, input logic [31:0] exp_pc,
                     input logic exp_en, input logic [2:0] exp_src);
    exp_t e;
    bus.stall_i       = st;
    bus.flush_i       = fl;
    bus.flushPC_i     = flpc;
    bus.recoverEX_i   = ex;
    bus.recoverEXPC_i = expc;
    bus.recoverID_i   = id;
    bus.recoverIDPC_i = idpc;
    bus.btbTaken_i    = btb;
    bus.btbTarget_i   = btbpc;
    #1;
    check({tag, "/squash"}, 32'(bus.squashFS1_o), 32'(exp_sq));
    e.tag = tag; e.pc = exp_pc; e.en = exp_en; e.src = exp_src;
    sb.push_back(e);
    @(posedge clk);
    #1;
    set_idle();
    #1;
    e = sb.pop_front();
    check({e.tag, "/pc"},  bus.pc_o,                 e.pc);
    check({e.tag, "/en"},  32'(bus.fetchEn_o),       32'(e.en));
    check({e.tag, "/src"}, 32'(bus.redirectSrc_o),   32'(e.src));
  endtask

  task automatic idle(input string tag, input logic [31:0] exp_pc,
                      input logic exp_en, input logic [2:0] exp_src);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, exp_pc, exp_en, exp_src);
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    @(posedge clk);
    #1;

    // Reset and release
    idle("reset", 32'h1000, 0, 0);
    reset = 1'b0;
    idle("release", 32'h1000, 1, 0);
    idle("seq1", 32'h1020, 1, 0);
    idle("seq2", 32'h1040, 1, 0);

    // BTB taken: no squash, no bubble
    cyc("btb", 0, 0, 0, 0, 0, 0, 0, 1, 32'h2000, 0, 32'h2000, 1, 1);
    idle("btb_next", 32'h2020, 1, 0);

    // Flush and EX together: flush wins, two bubbles
    cyc("flush_ex", 0, 1, 32'h4000, 1, 32'h3000, 0, 0, 0, 0, 1, 32'h4000, 0, 4);
    idle("refill1", 32'h4000, 0, 4);
    idle("refill2", 32'h4000, 1, 4);
    idle("after_refill", 32'h4020, 1, 0);

    // Stall for 5 cycles with EX then flush pending; later weaker EX ignored
    cyc("hold1_ex", 1, 0, 0, 1, 32'h3000, 0, 0, 0, 0, 0, 32'h4020, 0, 0);
    cyc("hold2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4020, 0, 0);
    cyc("hold3_fl", 1, 1, 32'h5000, 0, 0, 0, 0, 0, 0, 0, 32'h4020, 0, 0);
    cyc("hold4", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4020, 0, 0);
    cyc("hold5_ex", 1, 0, 0, 1, 32'h3000, 0, 0, 0, 0, 0, 32'h4020, 0, 0);
    cyc("unstall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5000, 0, 4);
    idle("unstall_r1", 32'h5000, 0, 4);
    idle("unstall_r2", 32'h5000, 1, 4);
    idle("unstall_seq", 32'h5020, 1, 0);

    // ID recovery stays in RUN
    cyc("id", 0, 0, 0, 0, 0, 1, 32'h6000, 0, 0, 1, 32'h6000, 1, 2);

    // EX recovery, then flush restarts the refill
    cyc("ex", 0, 0, 0, 1, 32'h7000, 0, 0, 0, 0, 1, 32'h7000, 0, 3);
    cyc("refill_flush", 0, 1, 32'h8000, 0, 0, 0, 0, 0, 0, 0, 32'h8000, 0, 4);
    idle("restart1", 32'h8000, 0, 4);
    idle("restart2", 32'h8000, 1, 4);
    idle("restart_seq", 32'h8020, 1, 0);

    // ID/BTB ignored while stalled; no pending -> resume at same PC
    cyc("stall_id", 1, 0, 0, 0, 0, 1, 32'h9000, 1, 32'hB000, 0, 32'h8020, 0, 0);
    idle("stall_rel", 32'h8020, 1, 0);
    idle("stall_seq", 32'h8040, 1, 0);

    // ID beats BTB
    cyc("id_btb", 0, 0, 0, 0, 0, 1, 32'hA000, 1, 32'hB000, 1, 32'hA000, 1, 2);

    // Silent wrap
    cyc("to_top", 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFE0, 0, 32'hFFFF_FFE0, 1, 1);
    idle("wrap", 32'h0000_0000, 1, 0);

    // Reset mid-REFILL drops the counter
    cyc("pre_rst_fl", 0, 1, 32'h4000, 0, 0, 0, 0, 0, 0, 1, 32'h4000, 0, 4);
    reset = 1'b1;
    idle("rst_refill", 32'h1000, 0, 0);
    reset = 1'b0;
    idle("rst_refill_rel", 32'h1000, 1, 0);
    idle("rst_refill_seq", 32'h1020, 1, 0);

    // Reset mid-HOLD drops the pending entry
    cyc("pre_rst_hold", 1, 0, 0, 1, 32'h3000, 0, 0, 0, 0, 0, 32'h1020, 0, 0);
    reset = 1'b1;
    cyc("rst_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 0, 0);
    reset = 1'b0;
    idle("rst_hold_rel", 32'h1000, 1, 0);
    idle("rst_hold_seq", 32'h1020, 1, 0);

`ifdef FETCH_REDIRECT_STATS_EN
    check("stat_flush_clr", 32'(bus.statFlush_o), 32'd0);
    check("stat_ex_clr", 32'(bus.statEX_o), 32'd0);
    cyc("sid1", 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 1, 32'h100, 1, 2);
    cyc("sid2", 0, 0, 0, 0, 0, 1, 32'h200, 0, 0, 1, 32'h200, 1, 2);
    cyc("sid3", 0, 0, 0, 0, 0, 1, 32'h300, 0, 0, 1, 32'h300, 1, 2);
    check("stat_id3", 32'(bus.statID_o), 32'd3);
    bus.recoverID_i   = 1'b1;
    bus.recoverIDPC_i = 32'h400;
    repeat (70000) @(posedge clk);
    #1;
    set_idle();
    check("stat_id_sat", 32'(bus.statID_o), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
